uart_rx: RTL

- UART receiver, 16× oversampling, sitting directly downstream of the mod-M baud tick counter.
- Its `s_tick` input is that counter's `max_tick`.
- Deserialises an asynchronous serial line into parallel words and flags framing and parity errors.
- Delivers each word with a one-cycle done strobe to game-logic consumers such as the command decoder or FIFO.

---
 rtl/uart_rx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling: deserialises rx into DBIT-wide words,
// with optional parity, framing/parity error flags and a one-cycle done strobe.
module uart_rx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          r_state;
  logic [SW-1:0]   r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_b;
  logic            r_p;
  logic            r_par_mis;
  logic            r_edge_pend;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_frame_err;
  logic            r_parity_err;

  logic r_rx_meta;
  logic r_rx_s;
  logic r_rx_q;
  logic w_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_q    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_q    <= r_rx_s;
    end
  end

  assign w_fall = r_rx_q & ~r_rx_s;

  // An edge arriving on the STOP->IDLE edge is remembered so the next frame is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_s          <= '0;
      r_n          <= '0;
      r_b          <= '0;
      r_p          <= 1'b0;
      r_par_mis    <= 1'b0;
      r_edge_pend  <= 1'b0;
      r_dout       <= '0;
      r_done       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_edge_pend <= 1'b0;
          if (w_fall || r_edge_pend) begin
            r_state <= START;
            r_s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (r_s == SW'(7)) begin
              if (!r_rx_s) begin
                r_state <= DATA;
                r_s     <= '0;
                r_n     <= '0;
                r_p     <= (PARITY_ODD != 0);
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (r_s == SW'(15)) begin
              r_s <= '0;
              r_b <= {r_rx_s, r_b[DBIT-1:1]};
              r_p <= r_p ^ r_rx_s;
              if (r_n == NW'(DBIT - 1)) begin
                r_state <= (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                r_n <= r_n + NW'(1);
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (r_s == SW'(15)) begin
              r_par_mis <= r_p ^ r_rx_s;
              r_s       <= '0;
              r_state   <= STOP;
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (r_s == SW'(SB_TICK - 1)) begin
              r_dout       <= r_b;
              r_frame_err  <= ~r_rx_s;
              r_parity_err <= (PARITY_EN != 0) ? r_par_mis : 1'b0;
              r_done       <= 1'b1;
              r_edge_pend  <= w_fall;
              r_state      <= IDLE;
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_frame_err;
  assign parity_err   = r_parity_err;
  assign busy         = (r_state != IDLE);

endmodule
